// File: rtl/comparator_seq_pkg.sv
// Shared types for the sequential magnitude comparator: FSM states,
// {e,g,l} result encodings and the digit-index width helper.
package comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Result vectors are ordered {e, g, l}.
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_EQ   = 3'b100;
  localparam logic [2:0] RES_GT   = 3'b010;
  localparam logic [2:0] RES_LT   = 3'b001;

  function automatic int idx_width(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/comparator_seq_digit.sv
// Combinational unsigned DIGIT-bit compare; the parameterised form of the
// old 2-bit structural comparator.
module comparator_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  output logic             o_e,
  output logic             o_g,
  output logic             o_l
);

  assign o_e = (i_a == i_b);
  assign o_g = (i_a >  i_b);
  assign o_l = (i_a <  i_b);

endmodule

// File: rtl/comparator_seq.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per cycle with early
// exit. Define COMPARATOR_SEQ_SIGNED_EN for two's-complement operands.
module comparator_seq
  import comparator_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             e,
  output logic             g,
  output logic             l
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW   = idx_width(NDIG);
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

  state_t           r_state;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_res;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_in_a;
  logic [WIDTH-1:0] w_in_b;
  logic             w_dig_e;
  logic             w_dig_g;
  logic             w_dig_l;

`ifdef COMPARATOR_SEQ_SIGNED_EN
  // Flipping the sign bit maps two's-complement order onto unsigned order.
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);
  assign w_in_a = a ^ MSB_MASK;
  assign w_in_b = b ^ MSB_MASK;
`else
  assign w_in_a = a;
  assign w_in_b = b;
`endif

  // Operands shift left each step, so the current digit is always on top.
  comparator_digit #(.DIGIT(DIGIT)) u_digit (
    .i_a (r_a[WIDTH-1 -: DIGIT]),
    .i_b (r_b[WIDTH-1 -: DIGIT]),
    .o_e (w_dig_e),
    .o_g (w_dig_g),
    .o_l (w_dig_l)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= RES_NONE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        // The edge that ends the done cycle is already an IDLE edge, which
        // gives latency+1 back-to-back throughput.
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= w_in_a;
            r_b     <= w_in_b;
            r_idx   <= '0;
            r_res   <= RES_NONE;
            r_busy  <= 1'b1;
            r_state <= CMP;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        CMP: begin
          if (w_dig_g) begin
            r_res   <= RES_GT;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (w_dig_l) begin
            r_res   <= RES_LT;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (w_dig_e && (r_idx == LAST_IDX)) begin
            r_res   <= RES_EQ;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + IW'(1);
            r_a   <= r_a << DIGIT;
            r_b   <= r_b << DIGIT;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign {e, g, l} = r_res;

endmodule

// File: tb/tb_comparator_seq.sv
// Self-checking bench for comparator_seq (WIDTH=8, DIGIT=2) with an expected
// result/latency scoreboard filled at start and drained at done.
module tb_comparator_seq;

  localparam int WIDTH = 8;
  localparam int DIGIT = 2;
  localparam int NDIG  = WIDTH / DIGIT;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             e;
  logic             g;
  logic             l;

  logic [2:0] exp_q[$];
  int         lat_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  comparator_seq #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .e     (e),
    .g     (g),
    .l     (l)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] model_res(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef COMPARATOR_SEQ_SIGNED_EN
    if ($signed(x) > $signed(y)) return 3'b010;
    if ($signed(x) < $signed(y)) return 3'b001;
`else
    if (x > y) return 3'b010;
    if (x < y) return 3'b001;
`endif
    return 3'b100;
  endfunction

  // Cycles from the accepting edge to done rising: index of first differing digit + 1.
  function automatic int model_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] d;
    d = x ^ y;
    for (int k = 0; k < NDIG; k++) begin
      if (d[WIDTH-1 -: DIGIT] != '0) return k + 1;
      d = d << DIGIT;
    end
    return NDIG;
  endfunction

  task automatic push_exp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    exp_q.push_back(model_res(x, y));
    lat_q.push_back(model_lat(x, y));
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge E0.
  task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input bit keep);
    start = 1'b1;
    a     = x;
    b     = y;
    push_exp(x, y);
    @(posedge clk);
    @(negedge clk);
    if (!keep) start = 1'b0;
  endtask

  // Counts edges after E0 until done is seen at a negedge (bounded).
  task automatic wait_done(input bit scramble, output int cyc, output bit seen);
    cyc  = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (scramble) begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
      end
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++; if ({e, g, l} !== 3'b000) begin n_fail++; $display("FAIL reset_egl got=%b exp=000", {e, g, l}); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_compare(input string name, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    int         cyc;
    bit         seen;
    logic [2:0] exp_r;
    int         exp_l;
    logic [2:0] held;
    issue(x, y, 1'b0);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy got=%b exp=1", name, busy); end
    n_checks++; if ({e, g, l} !== 3'b000) begin n_fail++; $display("FAIL %s_cleared got=%b exp=000", name, {e, g, l}); end
    wait_done(1'b0, cyc, seen);
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_timeout got=no_done exp=done", name);
      exp_q.delete();
      lat_q.delete();
      return;
    end
    exp_r = exp_q.pop_front();
    exp_l = lat_q.pop_front();
    n_checks++; if (cyc !== exp_l) begin n_fail++; $display("FAIL %s_latency got=%0d exp=%0d", name, cyc, exp_l); end
    n_checks++; if ({e, g, l} !== exp_r) begin n_fail++; $display("FAIL %s_egl got=%b exp=%b (a=%h b=%h)", name, {e, g, l}, exp_r, x, y); end
    held = {e, g, l};
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL %s_pulse got=%b exp=0", name, done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_idle_busy got=%b exp=0", name, busy); end
    @(negedge clk);
    n_checks++; if ({e, g, l} !== exp_r) begin n_fail++; $display("FAIL %s_hold got=%b exp=%b", name, {e, g, l}, held); end
  endtask

  task automatic test_random;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    for (int i = 0; i < 16; i++) begin
      x = 8'($urandom_range(0, 255));
      case (i % 3)
        0:       y = x;
        1:       y = x ^ (8'(1) << $urandom_range(0, 7));
        default: y = 8'($urandom_range(0, 255));
      endcase
      test_compare("random", x, y);
    end
  endtask

  task automatic test_ignored_inputs;
    int         cyc;
    bit         seen;
    int         extra;
    logic [2:0] exp_r;
    int         exp_l;
    issue(8'h3C, 8'h3C, 1'b1);
    wait_done(1'b1, cyc, seen);
    start = 1'b0;
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL ignored_timeout got=no_done exp=done");
      exp_q.delete();
      lat_q.delete();
      return;
    end
    exp_r = exp_q.pop_front();
    exp_l = lat_q.pop_front();
    n_checks++; if (cyc !== exp_l) begin n_fail++; $display("FAIL ignored_latency got=%0d exp=%0d", cyc, exp_l); end
    n_checks++; if ({e, g, l} !== exp_r) begin n_fail++; $display("FAIL ignored_egl got=%b exp=%b", {e, g, l}, exp_r); end
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) extra++;
    end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL ignored_single_pulse got=%0d exp=0 extra dones", extra); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignored_busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid;
    int extra;
    issue(8'hA5, 8'hA5, 1'b0);
    void'(exp_q.pop_front());
    void'(lat_q.pop_front());
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done got=%b exp=0", done); end
    n_checks++; if ({e, g, l} !== 3'b000) begin n_fail++; $display("FAIL rstmid_egl got=%b exp=000", {e, g, l}); end
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) extra++;
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL rstmid_no_done got=%0d exp=0 active cycles", extra); end
    test_compare("after_rst", 8'h5A, 8'h5B);
  endtask

  task automatic test_back_to_back;
    int         cyc;
    bit         seen;
    logic [2:0] exp_r;
    int         exp_l;
    issue(8'h01, 8'h02, 1'b1);
    wait_done(1'b0, cyc, seen);
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL b2b_first_timeout got=no_done exp=done");
      start = 1'b0;
      exp_q.delete();
      lat_q.delete();
      return;
    end
    exp_r = exp_q.pop_front();
    exp_l = lat_q.pop_front();
    n_checks++; if (cyc !== exp_l) begin n_fail++; $display("FAIL b2b_first_latency got=%0d exp=%0d", cyc, exp_l); end
    n_checks++; if ({e, g, l} !== exp_r) begin n_fail++; $display("FAIL b2b_first_egl got=%b exp=%b", {e, g, l}, exp_r); end
    a = 8'hFF;
    b = 8'h00;
    push_exp(8'hFF, 8'h00);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_busy got=%b exp=1", busy); end
    n_checks++; if ({done, e, g, l} !== 4'b0000) begin n_fail++; $display("FAIL b2b_accept_clear got=%b exp=0000", {done, e, g, l}); end
    wait_done(1'b0, cyc, seen);
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL b2b_second_timeout got=no_done exp=done");
      exp_q.delete();
      lat_q.delete();
      return;
    end
    exp_r = exp_q.pop_front();
    exp_l = lat_q.pop_front();
    n_checks++; if (cyc !== exp_l) begin n_fail++; $display("FAIL b2b_second_latency got=%0d exp=%0d", cyc, exp_l); end
    n_checks++; if ({e, g, l} !== exp_r) begin n_fail++; $display("FAIL b2b_second_egl got=%b exp=%b", {e, g, l}, exp_r); end
    @(negedge clk);
    n_checks++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL b2b_idle got=%b exp=00", {busy, done}); end
  endtask

  initial begin
    test_reset();
    test_compare("equal", 8'hA5, 8'hA5);
    test_compare("early", 8'h80, 8'h7F);
    test_compare("late", 8'h12, 8'h13);
    test_compare("zero", 8'h00, 8'h00);
    test_random();
    test_ignored_inputs();
    test_reset_mid();
    test_back_to_back();
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
